// File: rtl/flash_prog_seq.sv
// flash_prog_seq
//   Issues the JEDEC unlock/command sequence for a byte program or a sector
//   erase to a parallel NOR flash. It then polls DQ7 (data polling) until the
//   operation completes. If polling does not finish in time, the block aborts
//   with a reset (F0) write and sets a sticky error flag.
//
//   Every output is registered. The output registers are loaded from the
//   decode of the next state, so each output already shows the values for a
//   state during the first cycle of that state.
//
// Ports
//   m2             : clock, rising edge
//   reset          : asynchronous reset, active high
//   req            : start request, only sampled in IDLE
//   req_erase      : 1 = sector erase, 0 = byte program
//   req_addr       : target flash address (19 bits)
//   req_data       : byte to program (not used for erase)
//   busy           : high in every state except IDLE
//   done           : one-cycle completion pulse
//   error          : sticky timeout flag, cleared when the next request is accepted
//   flash_addr_out : flash address bus
//   flash_data_out : flash write data
//   flash_data_in  : flash read data (only DQ7 is used)
//   flash_ce/we/oe : flash strobes, all active low
//   bus_own        : high while the block drives the flash bus
//
// state    | meaning
// IDLE     | waiting for req
// WR_LO    | write strobe low for the current command entry
// WR_HI    | strobe high, address and data held, advance the entry index
// POLL     | read cycle, compare DQ7 against the completion value
// ABORT_LO | F0 reset write after a timeout, strobe low
// ABORT_HI | F0 reset write, strobe high
// DONE     | pulse done, then return to IDLE
module flash_prog_seq #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [18:0] ADDR_UNLOCK1   = 19'h00555,
  parameter logic [18:0] ADDR_UNLOCK2   = 19'h002AA
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        req,
  input  logic        req_erase,
  input  logic [18:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [18:0] flash_addr_out,
  output logic [7:0]  flash_data_out,
  input  logic [7:0]  flash_data_in,
  output logic        flash_ce,
  output logic        flash_we,
  output logic        flash_oe,
  output logic        bus_own
);

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, POLL, ABORT_LO, ABORT_HI, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [15:0] tmr, tmr_nxt;
  logic        error_nxt;
  logic        erase_q;
  logic [18:0] addr_q;
  logic [7:0]  data_q;

  logic [18:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic [2:0]  last_idx;
  logic        dq7_match;

  logic        busy_nxt, done_nxt, ce_nxt, we_nxt, oe_nxt, own_nxt;
  logic [18:0] faddr_nxt;
  logic [7:0]  fdata_nxt;

  logic        unused_dq;
  assign unused_dq = ^flash_data_in[6:0];

  assign last_idx  = erase_q ? 3'd5 : 3'd3;
  assign dq7_match = flash_data_in[7] == (erase_q ? 1'b1 : data_q[7]);

  // Next state, command index, poll counter and error flag
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tmr_nxt   = tmr;
    error_nxt = error;
    case (state)
      IDLE: if (req) begin
        state_nxt = WR_LO;
        idx_nxt   = 3'd0;
        error_nxt = 1'b0;
      end
      WR_LO: state_nxt = WR_HI;
      WR_HI: if (idx == last_idx) begin
        state_nxt = POLL;
        tmr_nxt   = 16'd0;
      end else begin
        state_nxt = WR_LO;
        idx_nxt   = idx + 3'd1;
      end
      // A match wins over a timeout that happens on the same cycle
      POLL: if (dq7_match) begin
        state_nxt = DONE;
      end else if (tmr == TIMEOUT_CYCLES - 16'd1) begin
        state_nxt = ABORT_LO;
        error_nxt = 1'b1;
      end else begin
        tmr_nxt = tmr + 16'd1;
      end
      ABORT_LO: state_nxt = ABORT_HI;
      ABORT_HI: state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Command list lookup. This uses the index of the next write, so the entry
  // is ready when the output registers load the values for WR_LO. Entry 0 is
  // the same for both lists, so the latch of req_erase during acceptance is
  // not needed yet.
  always_comb begin
    cmd_addr = ADDR_UNLOCK1;
    cmd_data = 8'hAA;
    case (idx_nxt)
      3'd0: begin cmd_addr = ADDR_UNLOCK1; cmd_data = 8'hAA; end
      3'd1: begin cmd_addr = ADDR_UNLOCK2; cmd_data = 8'h55; end
      3'd2: begin cmd_addr = ADDR_UNLOCK1; cmd_data = erase_q ? 8'h80 : 8'hA0; end
      3'd3: begin
        cmd_addr = erase_q ? ADDR_UNLOCK1 : addr_q;
        cmd_data = erase_q ? 8'hAA : data_q;
      end
      3'd4: begin cmd_addr = ADDR_UNLOCK2; cmd_data = 8'h55; end
      3'd5: begin cmd_addr = addr_q; cmd_data = 8'h30; end
      default: begin cmd_addr = ADDR_UNLOCK1; cmd_data = 8'hAA; end
    endcase
  end

  // Output decode of the next state. Address and data hold unless a state drives them.
  always_comb begin
    busy_nxt  = 1'b1;
    done_nxt  = 1'b0;
    ce_nxt    = 1'b1;
    we_nxt    = 1'b1;
    oe_nxt    = 1'b1;
    own_nxt   = 1'b1;
    faddr_nxt = flash_addr_out;
    fdata_nxt = flash_data_out;
    case (state_nxt)
      IDLE: begin
        busy_nxt = 1'b0;
        own_nxt  = 1'b0;
      end
      WR_LO: begin
        ce_nxt    = 1'b0;
        we_nxt    = 1'b0;
        faddr_nxt = cmd_addr;
        fdata_nxt = cmd_data;
      end
      POLL: begin
        ce_nxt    = 1'b0;
        oe_nxt    = 1'b0;
        faddr_nxt = addr_q;
      end
      ABORT_LO: begin
        ce_nxt    = 1'b0;
        we_nxt    = 1'b0;
        faddr_nxt = addr_q;
        fdata_nxt = 8'hF0;
      end
      DONE: begin
        done_nxt = 1'b1;
        own_nxt  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge m2 or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= 3'd0;
      tmr            <= 16'd0;
      error          <= 1'b0;
      erase_q        <= 1'b0;
      addr_q         <= 19'd0;
      data_q         <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      flash_ce       <= 1'b1;
      flash_we       <= 1'b1;
      flash_oe       <= 1'b1;
      bus_own        <= 1'b0;
      flash_addr_out <= 19'd0;
      flash_data_out <= 8'd0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      tmr            <= tmr_nxt;
      error          <= error_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      flash_ce       <= ce_nxt;
      flash_we       <= we_nxt;
      flash_oe       <= oe_nxt;
      bus_own        <= own_nxt;
      flash_addr_out <= faddr_nxt;
      flash_data_out <= fdata_nxt;
      if (state == IDLE && req) begin
        erase_q <= req_erase;
        addr_q  <= req_addr;
        data_q  <= req_data;
      end
    end
  end

endmodule
